// File: rtl/memdma_if.sv
// memdma_if: cs/rd/wr/nwait bus between the memdma engine and one hub master port.
//   master: engine side (drives strobes, addr, wdata, mask; receives nwait, rdata)
//   slave : hub side
interface memdma_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [1:0]  mask;
  logic        nwait;
  logic [25:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (
    output cs, rd, wr, mask, addr, wdata,
    input  nwait, rdata
  );

  modport slave (
    input  cs, rd, wr, mask, addr, wdata,
    output nwait, rdata
  );
endinterface

// File: rtl/memdma.sv
// memdma: bus-master copy/fill engine. Moves len halfwords from src_addr to
// dst_addr with alternating single reads and writes on the hub port.
// Ports:
//   clk, reset (async active-low)
//   start, abort         : control pulses
//   fill, pattern        : fill mode select / fill value (sampled at start)
//   src_addr, dst_addr   : byte addresses, bit 0 ignored
//   len                  : halfword count
//   busy, done, remaining: status
//   bus                  : memdma_if.master (cs/rd/wr/mask/addr/wdata/nwait/rdata)
// Build option: define MEMDMA_FILL_EN to honour fill/pattern; otherwise the
// engine always copies and the fill data path is not built.
module memdma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             fill,
  input  logic [25:0]      src_addr,
  input  logic [25:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      pattern,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining,
  memdma_if.master         bus
);

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [DW-1:0]    buf_q, buf_d, wdata_q, wdata_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic             abort_q, abort_d;

  logic             start_acc;
  logic             start_fill;
  logic             run_fill;
  logic [DW-1:0]    wr_word;
  logic [DW-1:0]    start_word;
  logic             abort_pend;
  logic [AW-1:0]    src_start, dst_start;

  assign start_acc  = (state_q == S_IDLE) && start && (len != '0);
  assign abort_pend = abort_q | abort;
  assign src_start  = src_addr & ~AW'(1);
  assign dst_start  = dst_addr & ~AW'(1);

`ifdef MEMDMA_FILL_EN
  logic          fill_q;
  logic [DW-1:0] pat_q;

  // Fill mode and pattern are held for the whole transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q <= 1'b0;
      pat_q  <= '0;
    end else if (start_acc) begin
      fill_q <= fill;
      pat_q  <= pattern;
    end
  end

  assign start_fill = fill;
  assign run_fill   = fill_q;
  assign wr_word    = fill_q ? pat_q : buf_q;
  assign start_word = pattern;
`else
  logic unused_fill;
  assign unused_fill = ^{fill, pattern};
  assign start_fill  = 1'b0;
  assign run_fill    = 1'b0;
  assign wr_word     = buf_q;
  assign start_word  = buf_q;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
    end
  end

  // Next state and next registered outputs; strobes default low (gap cycles).
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    abort_d = abort_q | abort;

    case (state_q)
      S_IDLE: begin
        // Abort while idle, or together with start, is dropped.
        abort_d = 1'b0;
        if (start) begin
          if (len == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rem_d   = '0;
          end else begin
            src_d  = src_start;
            dst_d  = dst_start;
            rem_d  = len;
            busy_d = 1'b1;
            cs_d   = 1'b1;
            if (start_fill) begin
              state_d = S_WR;
              wr_d    = 1'b1;
              addr_d  = dst_start;
              wdata_d = start_word;
            end else begin
              state_d = S_RD;
              rd_d    = 1'b1;
              addr_d  = src_start;
            end
          end
        end
      end

      S_RD: begin
        if (bus.nwait) begin
          buf_d   = bus.rdata;
          src_d   = src_q + AW'(2);
          state_d = S_RD_GAP;
        end else begin
          cs_d = 1'b1;
          rd_d = 1'b1;
        end
      end

      S_RD_GAP: begin
        if (abort_pend) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_WR;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q;
          wdata_d = wr_word;
        end
      end

      S_WR: begin
        if (bus.nwait) begin
          dst_d   = dst_q + AW'(2);
          rem_d   = rem_q - LEN_W'(1);
          state_d = S_WR_GAP;
        end else begin
          cs_d = 1'b1;
          wr_d = 1'b1;
        end
      end

      S_WR_GAP: begin
        if ((rem_q == '0) || abort_pend) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (run_fill) begin
          state_d = S_WR;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = dst_q;
          wdata_d = wr_word;
        end else begin
          state_d = S_RD;
          cs_d    = 1'b1;
          rd_d    = 1'b1;
          addr_d  = src_q;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        abort_d = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;
  assign bus.cs    = cs_q;
  assign bus.rd    = rd_q;
  assign bus.wr    = wr_q;
  assign bus.mask  = 2'b00;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_memdma.sv
// tb_memdma: directed self-checking bench for memdma with a simple hub model
// (programmable wait states, address-derived read data) and a bus access log.
module tb_memdma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, fill;
  logic [25:0] src_addr, dst_addr;
  logic [15:0] len, pattern;
  logic        busy, done;
  logic [15:0] remaining;

  memdma_if bus ();

  memdma #(.LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .fill      (fill),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Hub model: stall cycles per access and read data.
  int   stall = 0;
  int   wcnt  = 0;

  function automatic logic [15:0] model_read(input logic [25:0] a);
    case (a)
      26'h0000100: return 16'h1111;
      26'h0000102: return 16'h2222;
      26'h0000104: return 16'h3333;
      default:     return a[15:0] ^ 16'hBEEF;
    endcase
  endfunction

  assign bus.nwait = (wcnt >= stall);
  assign bus.rdata = model_read(bus.addr);

  always @(posedge clk) begin
    if (bus.cs && !bus.nwait) wcnt <= wcnt + 1;
    else                      wcnt <= 0;
  end

  // Access log and protocol watch, sampled mid-cycle.
  bit          log_wr[$];
  logic [25:0] log_addr[$];
  logic [15:0] log_data[$];
  int          stab_err = 0;
  int          gap_err  = 0;
  logic        p_cs = 1'b0, p_nw = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [25:0] p_addr = '0;
  logic [15:0] p_wdata = '0;

  always @(negedge clk) begin
    if (!reset) begin
      p_cs = 1'b0;
    end else begin
      if (p_cs && !p_nw &&
          ({bus.cs, bus.rd, bus.wr, bus.addr, bus.wdata} !== {p_cs, p_rd, p_wr, p_addr, p_wdata}))
        stab_err++;
      if (p_cs && p_nw && bus.cs) gap_err++;
      if (bus.cs && bus.nwait) begin
        log_wr.push_back(bus.wr);
        log_addr.push_back(bus.addr);
        log_data.push_back(bus.wr ? bus.wdata : bus.rdata);
      end
      p_cs = bus.cs; p_nw = bus.nwait; p_rd = bus.rd; p_wr = bus.wr;
      p_addr = bus.addr; p_wdata = bus.wdata;
    end
  end

  logic [15:0] rem_hist  [0:255];
  logic        cs_hist   [0:255];
  logic        busy_hist [0:255];

  // Launch a transfer (start sampled at edge 0) and wait for done; cycle c is the
  // cycle after edge c-1. abort_at/restart_at pick cycles to pulse abort/start.
  task automatic run(input int abort_at, input int restart_at, input int budget,
                     output int done_cyc);
    int c;
    log_wr.delete(); log_addr.delete(); log_data.delete();
    stab_err = 0; gap_err = 0;
    @(negedge clk);
    start = 1'b1;
    abort = (abort_at == 0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    c = 1; done_cyc = -1;
    while (c <= budget) begin
      rem_hist[c] = remaining; cs_hist[c] = bus.cs; busy_hist[c] = busy;
      if (done) begin
        done_cyc = c;
        break;
      end
      abort = (c == abort_at);
      start = (c == restart_at);
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      c++;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL run_timeout: no done within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int n, input bit ew[16],
                           input logic [25:0] ea[16], input logic [15:0] ed[16]);
    checks++;
    if (log_addr.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d accesses expected %0d", name, log_addr.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (log_wr[i] !== ew[i] || log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
          errors++;
          $display("FAIL %s_acc[%0d]: got wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                   name, i, log_wr[i], log_addr[i], log_data[i], ew[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; fill = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; pattern = '0;
    #12;
    checks++;
    if ({busy, done, remaining} !== 18'd0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b rem=%h expected 0 0 0000", busy, done, remaining);
    end
    checks++;
    if ({bus.cs, bus.rd, bus.wr, bus.mask} !== 5'd0) begin
      errors++;
      $display("FAIL reset_strobes: got cs=%b rd=%b wr=%b mask=%b expected all 0",
               bus.cs, bus.rd, bus.wr, bus.mask);
    end
    checks++;
    if ({bus.addr, bus.wdata} !== 42'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0", bus.addr, bus.wdata);
    end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_copy(input int st, input int exp_done, input string name);
    int dc;
    bit          ew[16] = '{0,1,0,1,0,1,0,0,0,0,0,0,0,0,0,0};
    logic [25:0] ea[16] = '{26'h100,26'h200,26'h102,26'h202,26'h104,26'h204,
                            0,0,0,0,0,0,0,0,0,0};
    logic [15:0] ed[16] = '{16'h1111,16'h1111,16'h2222,16'h2222,16'h3333,16'h3333,
                            0,0,0,0,0,0,0,0,0,0};
    stall = st; src_addr = 26'h100; dst_addr = 26'h200; len = 16'd3;
    run(-1, -1, 200, dc);
    checks++;
    if (dc != exp_done) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d expected %0d", name, dc, exp_done);
    end
    check_log(name, 6, ew, ea, ed);
    checks++;
    if (cs_hist[1] !== 1'b1 || busy_hist[1] !== 1'b1 || rem_hist[1] !== 16'd3) begin
      errors++;
      $display("FAIL %s_cycle1: got cs=%b busy=%b rem=%0d expected 1 1 3",
               name, cs_hist[1], busy_hist[1], rem_hist[1]);
    end
    if (st == 0) begin
      checks++;
      if (rem_hist[3] !== 16'd3 || rem_hist[4] !== 16'd2) begin
        errors++;
        $display("FAIL %s_rem_update: got c3=%0d c4=%0d expected 3 2", name, rem_hist[3], rem_hist[4]);
      end
    end
    checks++;
    if (dc > 0 && (busy_hist[dc] !== 1'b0 || rem_hist[dc] !== 16'd0)) begin
      errors++;
      $display("FAIL %s_end: got busy=%b rem=%0d expected 0 0", name, busy_hist[dc], rem_hist[dc]);
    end
    checks++;
    if (stab_err != 0 || gap_err != 0) begin
      errors++;
      $display("FAIL %s_protocol: got stab_err=%0d gap_err=%0d expected 0 0", name, stab_err, gap_err);
    end
  endtask

  task automatic test_len0();
    int dc;
    stall = 0; src_addr = 26'h100; dst_addr = 26'h200; len = 16'd0;
    run(-1, -1, 20, dc);
    checks++;
    if (dc != 1 || log_addr.size() != 0 || rem_hist[1] !== 16'd0 || busy_hist[1] !== 1'b0) begin
      errors++;
      $display("FAIL len0: got done_cyc=%0d accesses=%0d rem=%0d busy=%b expected 1 0 0 0",
               dc, log_addr.size(), rem_hist[1], busy_hist[1]);
    end
  endtask

  task automatic test_wrap();
    int dc;
    bit          ew[16] = '{0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [25:0] ea[16] = '{26'h3FFFFFE,26'h1000,26'h0000000,26'h1002,
                            0,0,0,0,0,0,0,0,0,0,0,0};
    logic [15:0] ed[16] = '{16'h4111,16'h4111,16'hBEEF,16'hBEEF,
                            0,0,0,0,0,0,0,0,0,0,0,0};
    stall = 0; src_addr = 26'h3FFFFFE; dst_addr = 26'h1001; len = 16'd2;
    run(-1, -1, 100, dc);
    checks++;
    if (dc != 9) begin
      errors++;
      $display("FAIL wrap_done_cycle: got %0d expected 9", dc);
    end
    check_log("wrap", 4, ew, ea, ed);
  endtask

  task automatic test_abort();
    int dc;
    bit          ew[16] = '{0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [25:0] ea[16] = '{26'h100,26'h300,26'h102,0,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [15:0] ed[16] = '{16'h1111,16'h1111,16'h2222,0,0,0,0,0,0,0,0,0,0,0,0,0};
    stall = 3; src_addr = 26'h100; dst_addr = 26'h300; len = 16'd4;
    run(12, -1, 200, dc);
    checks++;
    if (dc != 16 || (dc > 0 && rem_hist[dc] !== 16'd3)) begin
      errors++;
      $display("FAIL abort_end: got done_cyc=%0d rem=%0d expected 16 3", dc, (dc > 0) ? rem_hist[dc] : 16'hFFFF);
    end
    check_log("abort", 3, ew, ea, ed);
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL abort_stable: got stab_err=%0d expected 0", stab_err);
    end
  endtask

  task automatic test_abort_ignored();
    int dc;
    // Abort while idle leaves no pending state.
    stall = 0; src_addr = 26'h104; dst_addr = 26'h400; len = 16'd1;
    @(negedge clk); abort = 1'b1; @(negedge clk); abort = 1'b0;
    run(-1, -1, 50, dc);
    checks++;
    if (dc != 5 || log_addr.size() != 2) begin
      errors++;
      $display("FAIL idle_abort: got done_cyc=%0d accesses=%0d expected 5 2", dc, log_addr.size());
    end
    // Abort together with start is dropped.
    src_addr = 26'h100; dst_addr = 26'h600; len = 16'd2;
    run(0, -1, 50, dc);
    checks++;
    if (dc != 9 || log_addr.size() != 4 || rem_hist[dc > 0 ? dc : 0] !== 16'd0) begin
      errors++;
      $display("FAIL start_abort: got done_cyc=%0d accesses=%0d expected 9 4", dc, log_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    // Second start while busy is ignored.
    stall = 0; src_addr = 26'h100; dst_addr = 26'h700; len = 16'd2;
    run(-1, 3, 50, dc);
    checks++;
    if (dc != 9 || log_addr.size() != 4) begin
      errors++;
      $display("FAIL busy_start: got done_cyc=%0d accesses=%0d expected 9 4", dc, log_addr.size());
    end
    checks++;
    if (log_addr.size() == 4 && log_addr[3] !== 26'h702) begin
      errors++;
      $display("FAIL busy_start_addr: got %h expected 0000702", log_addr[3]);
    end
  endtask

  task automatic test_fill();
    int dc;
`ifdef MEMDMA_FILL_EN
    bit          ew[16] = '{1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [25:0] ea[16] = '{26'h10,26'h12,26'h14,26'h16,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [15:0] ed[16] = '{16'hA5A5,16'hA5A5,16'hA5A5,16'hA5A5,0,0,0,0,0,0,0,0,0,0,0,0};
    stall = 0; fill = 1'b1; pattern = 16'hA5A5;
    src_addr = 26'h500; dst_addr = 26'h10; len = 16'd4;
    run(-1, -1, 50, dc);
    fill = 1'b0;
    checks++;
    if (dc != 9) begin
      errors++;
      $display("FAIL fill_done_cycle: got %0d expected 9", dc);
    end
    check_log("fill", 4, ew, ea, ed);
`else
    bit          ew[16] = '{0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [25:0] ea[16] = '{26'h100,26'h20,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [15:0] ed[16] = '{16'h1111,16'h1111,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    stall = 0; fill = 1'b1; pattern = 16'hA5A5;
    src_addr = 26'h100; dst_addr = 26'h20; len = 16'd1;
    run(-1, -1, 50, dc);
    fill = 1'b0;
    checks++;
    if (dc != 5) begin
      errors++;
      $display("FAIL nofill_done_cycle: got %0d expected 5", dc);
    end
    check_log("nofill", 2, ew, ea, ed);
`endif
  endtask

  task automatic test_reset_mid();
    int dc;
    stall = 5; src_addr = 26'h100; dst_addr = 26'h200; len = 16'd3;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cs !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got cs=%b busy=%b expected 1 1", bus.cs, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.cs, bus.rd, busy, done} !== 4'd0 || bus.addr !== 26'd0 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL midreset: got cs=%b rd=%b busy=%b done=%b addr=%h rem=%0d expected all 0",
               bus.cs, bus.rd, busy, done, bus.addr, remaining);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    stall = 0; src_addr = 26'h102; dst_addr = 26'h800; len = 16'd1;
    run(-1, -1, 50, dc);
    checks++;
    if (dc != 5 || log_addr.size() != 2) begin
      errors++;
      $display("FAIL midreset_recover: got done_cyc=%0d accesses=%0d expected 5 2", dc, log_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_copy(0, 13, "copy");
    test_copy(5, 43, "stall");
    test_len0();
    test_wrap();
    test_abort();
    test_abort_ignored();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
